// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Multi-cycle wide adder sequencer.  One SIZE-bit adder slice
//               is reused over CHUNKS clocks, least-significant chunk first,
//               with the carry held in a register between chunks.  The
//               result is W = SIZE*CHUNKS bits wide plus a carry out.
//               A start/busy/done handshake controls each operation.
//
// Parameters  : SIZE   - width of one adder slice / chunk in bits (>=1)
//               CHUNKS - number of chunks per operation (>=1)
//
// Ports       : clk    - rising-edge clock
//               rst    - synchronous active-high reset
//               start  - request a new addition (IDLE or DONE only)
//               a, b   - W-bit operands, captured on the accepting edge
//               cin    - carry into chunk 0, captured on the accepting edge
//               busy   - high while chunks are being processed (RUN)
//               done   - one-cycle pulse when sum/cout become valid
//               sum    - W-bit result, holds the last completed value
//               cout   - carry out of the top chunk, holds last value
//               ovf    - (SERIAL_ADD_OVF_EN only) two's-complement signed
//                        overflow of a+b+cin, updated with sum/cout
//
// Config      : `define SERIAL_ADD_OVF_EN to add the ovf output.
//
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int SIZE   = 4,
    parameter int CHUNKS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SIZE*CHUNKS-1:0] a,
    input  logic [SIZE*CHUNKS-1:0] b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [SIZE*CHUNKS-1:0] sum,
    output logic                   cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic                   ovf
`endif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_W      = SIZE * CHUNKS;
    localparam int c_IDXW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    // Chunk table is padded to a power of two so any index value is in range.
    localparam int c_NSLOTS = 1 << c_IDXW;
    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(CHUNKS - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_t            r_state, w_state_nxt;
    logic [c_IDXW-1:0] r_idx,   w_idx_nxt;
    logic              r_carry, w_carry_nxt;
    logic [c_W-1:0]    r_a,     w_a_nxt;
    logic [c_W-1:0]    r_b,     w_b_nxt;
    logic [c_W-1:0]    r_acc,   w_acc_nxt;
    logic [c_W-1:0]    r_sum,   w_sum_nxt;
    logic              r_cout,  w_cout_nxt;
    logic              r_busy,  w_busy_nxt;
    logic              r_done,  w_done_nxt;
    logic              r_ovf,   w_ovf_nxt;

    // ------------------------------------------------------------------------
    // Chunk selection: split the latched operands into SIZE-bit slots so the
    // current chunk is a plain array lookup by the index register.
    // ------------------------------------------------------------------------
    logic [SIZE-1:0] w_a_slot [c_NSLOTS];
    logic [SIZE-1:0] w_b_slot [c_NSLOTS];

    for (genvar k = 0; k < c_NSLOTS; k++) begin : g_slot
        if (k < CHUNKS) begin : g_used
            assign w_a_slot[k] = r_a[k*SIZE +: SIZE];
            assign w_b_slot[k] = r_b[k*SIZE +: SIZE];
        end else begin : g_pad
            assign w_a_slot[k] = '0;
            assign w_b_slot[k] = '0;
        end
    end

    logic [SIZE-1:0] w_a_chunk;
    logic [SIZE-1:0] w_b_chunk;
    logic [SIZE:0]   w_slice;     // {carry out, sum} of the shared slice
    logic [SIZE-1:0] w_slice_s;
    logic            w_slice_c;
    logic [c_W-1:0]  w_acc_upd;   // accumulator with the current chunk written
    logic            w_msb_cin;   // carry into the MSB of the current chunk

    assign w_a_chunk = w_a_slot[r_idx];
    assign w_b_chunk = w_b_slot[r_idx];

    // The one and only adder slice.
    assign w_slice   = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{SIZE{1'b0}}, r_carry};
    assign w_slice_s = w_slice[SIZE-1:0];
    assign w_slice_c = w_slice[SIZE];

    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB is recoverable
    // from the slice result without a second adder.
    assign w_msb_cin = w_a_chunk[SIZE-1] ^ w_b_chunk[SIZE-1] ^ w_slice_s[SIZE-1];

    always_comb begin
        w_acc_upd = r_acc;
        for (int k = 0; k < CHUNKS; k++) begin
            if (r_idx == c_IDXW'(k)) begin
                w_acc_upd[k*SIZE +: SIZE] = w_slice_s;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_carry_nxt = r_carry;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_acc_nxt   = r_acc;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        w_ovf_nxt   = r_ovf;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            // DONE accepts a new request exactly like IDLE so operations can
            // run back to back without an idle bubble.
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_carry_nxt = cin;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            // start is deliberately not looked at here: operands stay frozen
            // and nothing is queued.
            S_RUN: begin
                w_acc_nxt   = w_acc_upd;
                w_carry_nxt = w_slice_c;
                if (r_idx == c_LAST_IDX) begin
                    w_sum_nxt   = w_acc_upd;
                    w_cout_nxt  = w_slice_c;
                    w_ovf_nxt   = w_msb_cin ^ w_slice_c;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_carry <= w_carry_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_acc   <= w_acc_nxt;
            r_sum   <= w_sum_nxt;
            r_cout  <= w_cout_nxt;
            r_ovf   <= w_ovf_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef SERIAL_ADD_OVF_EN
    assign ovf = r_ovf;
`else
    // Overflow tracking is kept internal so the default build has no ovf port.
    logic w_ovf_unused;
    assign w_ovf_unused = r_ovf;
`endif

endmodule
`default_nettype wire
